// File: rtl/machine_timer.sv
// Machine-mode timer: 64-bit mtime/mtimecmp behind a word register port,
// advanced by the prescaler tick, driving a level MTIP interrupt.
module machine_timer #(
    parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [2:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic        timer_irq_o
);

    typedef enum logic [2:0] {
        IDX_MTIME_LO   = 3'd0,
        IDX_MTIME_HI   = 3'd1,
        IDX_CMP_LO     = 3'd2,
        IDX_CMP_HI     = 3'd3,
        IDX_CTRL       = 3'd4,
        IDX_MTIME_SNAP = 3'd5,
        IDX_RSVD6      = 3'd6,
        IDX_RSVD7      = 3'd7
    } reg_idx_t;

    reg_idx_t    idx;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [63:0] mtime_next;
    logic [31:0] snap;
    logic [31:0] read_mux;
    logic        en;
    logic        reload;
    logic        reached;

    assign idx     = reg_idx_t'(addr_i);
    assign reached = (mtime >= mtimecmp);

    // Read mux sees only registered state, so a same-cycle write is not visible.
    always_comb begin
        read_mux = '0;
        case (idx)
            IDX_MTIME_LO:   read_mux = mtime[31:0];
            IDX_MTIME_HI:   read_mux = mtime[63:32];
            IDX_CMP_LO:     read_mux = mtimecmp[31:0];
            IDX_CMP_HI:     read_mux = mtimecmp[63:32];
            IDX_CTRL:       read_mux = {30'b0, reload, en};
            IDX_MTIME_SNAP: read_mux = snap;
            default:        read_mux = '0;
        endcase
    end

    // A software write to either mtime half suppresses that cycle's tick entirely.
    always_comb begin
        mtime_next = mtime;
        if (we_i && idx == IDX_MTIME_LO) begin
            mtime_next[31:0] = wdata_i;
        end else if (we_i && idx == IDX_MTIME_HI) begin
            mtime_next[63:32] = wdata_i;
        end else if (tick_i && en) begin
            mtime_next = (reload && reached) ? '0 : mtime + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime       <= '0;
            mtimecmp    <= CMP_RST;
            en          <= 1'b0;
            reload      <= 1'b0;
            snap        <= '0;
            rdata_o     <= '0;
            rvalid_o    <= 1'b0;
            timer_irq_o <= 1'b0;
        end else begin
            mtime       <= mtime_next;
            rvalid_o    <= re_i;
            timer_irq_o <= en & reached;
            if (re_i) begin
                rdata_o <= read_mux;
            end
            if (re_i && idx == IDX_MTIME_LO) begin
                snap <= mtime[63:32];
            end
            if (we_i) begin
                case (idx)
                    IDX_CMP_LO: mtimecmp[31:0]  <= wdata_i;
                    IDX_CMP_HI: mtimecmp[63:32] <= wdata_i;
                    IDX_CTRL: begin
                        en     <= wdata_i[0];
                        reload <= wdata_i[1];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer: register reads are checked through an
// expected-value queue popped whenever rvalid_o is seen.
module tb_machine_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_i;
    logic        we_i;
    logic        re_i;
    logic [2:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        timer_irq_o;

    typedef struct {
        string       tag;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    machine_timer #(.CMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_i      (tick_i),
        .we_i        (we_i),
        .re_i        (re_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .rvalid_o    (rvalid_o),
        .timer_irq_o (timer_irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every rvalid_o pulse must match the oldest expected read.
    always @(negedge clk) begin
        if (rvalid_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", 64'(rvalid_o), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk(e.tag, 64'(rdata_o), 64'(e.data));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        we_i = 1'b1; addr_i = a; wdata_i = d;
        cyc();
        we_i = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] d);
        re_i = 1'b1; addr_i = a;
        sb.push_back('{tag, d});
        cyc();
        re_i = 1'b0;
        chk({tag, "_latency"}, 64'(rvalid_o), 64'd1);
    endtask

    task automatic tick();
        tick_i = 1'b1;
        cyc();
        tick_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] seq [5];
        logic        irq_seq [5];
        seq     = '{32'd1, 32'd2, 32'd0, 32'd1, 32'd2};
        irq_seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset with tick held high and a read strobe pending
        rst_n = 1'b0; tick_i = 1'b1; we_i = 1'b0; re_i = 1'b1;
        addr_i = 3'd0; wdata_i = '0;
        repeat (3) cyc();
        chk("rst_irq", 64'(timer_irq_o), 64'd0);
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        re_i = 1'b0; tick_i = 1'b0; rst_n = 1'b1;
        cyc();
        rd("rst_mtime_lo", 3'd0, 32'h0);
        rd("rst_mtime_hi", 3'd1, 32'h0);
        rd("rst_cmp_lo", 3'd2, 32'hFFFF_FFFF);
        rd("rst_cmp_hi", 3'd3, 32'hFFFF_FFFF);
        rd("rst_ctrl", 3'd4, 32'h0);
        cyc();
        chk("rvalid_idle", 64'(rvalid_o), 64'd0);

        // Count to compare value; IRQ one cycle after the reaching edge
        wr(3'd3, 32'h0);
        wr(3'd2, 32'd3);
        wr(3'd4, 32'd1);
        tick(); tick(); tick();
        chk("irq_not_yet", 64'(timer_irq_o), 64'd0);
        cyc();
        chk("irq_rise", 64'(timer_irq_o), 64'd1);
        rd("mtime_after_3", 3'd0, 32'd3);

        // Carry into high half, tear-free snapshot
        wr(3'd0, 32'hFFFF_FFFF);
        tick();
        rd("carry_lo", 3'd0, 32'h0);
        rd("snap_hi", 3'd5, 32'h1);
        cyc();
        chk("rvalid_pulse_end", 64'(rvalid_o), 64'd0);

        // Write wins over a simultaneous tick
        wr(3'd1, 32'h7);
        wr(3'd0, 32'h5);
        tick_i = 1'b1;
        wr(3'd0, 32'h10);
        tick_i = 1'b0;
        rd("write_wins_lo", 3'd0, 32'h10);
        rd("write_wins_hi", 3'd1, 32'h7);

        // Same-cycle read and write returns the old value
        re_i = 1'b1;
        sb.push_back('{"rw_same_idx", 32'd3});
        wr(3'd2, 32'h55);
        re_i = 1'b0;
        rd("rw_new_value", 3'd2, 32'h55);

        // Unmapped indices
        wr(3'd7, 32'hDEAD_BEEF);
        rd("unmapped7", 3'd7, 32'h0);
        rd("unmapped6", 3'd6, 32'h0);

        // Auto-reload at compare
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd2, 32'd2);
        wr(3'd3, 32'h0);
        wr(3'd1, 32'h0);
        wr(3'd0, 32'h0);
        wr(3'd4, 32'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            rd($sformatf("reload_seq%0d", i), 3'd0, seq[i]);
            chk($sformatf("reload_irq%0d", i), 64'(timer_irq_o), 64'(irq_seq[i]));
        end

        // 64-bit wrap drops the IRQ
        wr(3'd4, 32'd1);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd0, 32'hFFFF_FFFF);
        cyc();
        chk("irq_at_max", 64'(timer_irq_o), 64'd1);
        tick();
        cyc();
        chk("irq_after_wrap", 64'(timer_irq_o), 64'd0);
        rd("wrap_lo", 3'd0, 32'h0);
        rd("wrap_hi", 3'd1, 32'h0);

        // Reset in the middle of a read
        re_i = 1'b1; addr_i = 3'd4; rst_n = 1'b0;
        cyc();
        chk("rst_mid_read_rvalid", 64'(rvalid_o), 64'd0);
        re_i = 1'b0; rst_n = 1'b1;
        rd("post_rst_ctrl", 3'd4, 32'h0);
        rd("post_rst_cmp_lo", 3'd2, 32'hFFFF_FFFF);

        repeat (3) cyc();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
